// File: rtl/filter_ctrl.sv
// Configuration sequencer for the 32-channel input noise filter: defers flag
// changes while capture runs and blanks sample_valid until the filter flushes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACTIVE  | passing samples, no write outstanding
// ST_PENDING | write captured, waiting for run to fall (old flags in use)
// ST_APPLY   | one cycle: pending value moves into flags, ack issued
// ST_SETTLE  | sample_valid blanked while the filter pipeline flushes
module filter_ctrl #(
    parameter int SETTLE = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_flags,
    input  logic [5:0]  flags_in,
    input  logic        run,
    input  logic [31:0] raw_data,
    input  logic        raw_valid,
    input  logic [31:0] filt_data,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    output logic [5:0]  flags,
    output logic        cfg_pending,
    output logic        cfg_ack
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_PENDING,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [5:0]      pend, pend_nxt;
    logic [5:0]      flags_nxt;
    logic            ack_nxt;
    logic            pending_nxt;

    logic [31:0]     raw_d;
    logic            raw_valid_d;
    logic [31:0]     path_src;
    logic [31:0]     path_inv;
    logic [31:0]     path_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_SETTLE;
            cnt         <= CNT_LOAD;
            pend        <= '0;
            flags       <= '0;
            cfg_ack     <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pend        <= pend_nxt;
            flags       <= flags_nxt;
            cfg_ack     <= ack_nxt;
            cfg_pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        flags_nxt = flags;
        ack_nxt   = 1'b0;

        case (state)
            ST_ACTIVE: begin
                if (wr_flags) begin
                    pend_nxt  = flags_in;
                    state_nxt = run ? ST_PENDING : ST_APPLY;
                end
            end

            ST_PENDING: begin
                if (wr_flags) begin
                    pend_nxt = flags_in;
                end
                if (!run) begin
                    state_nxt = ST_APPLY;
                end
            end

            ST_APPLY: begin
                // A write landing exactly here is newer than pend, so it wins.
                flags_nxt = wr_flags ? flags_in : pend;
                ack_nxt   = 1'b1;
                cnt_nxt   = CNT_LOAD;
                state_nxt = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (wr_flags) begin
                    flags_nxt = flags_in;
                    pend_nxt  = flags_in;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = CNT_LOAD;
            end
        endcase

        pending_nxt = (state_nxt == ST_PENDING);
    end

    // Raw path is delayed one stage so it lines up with filt_data.
    always_ff @(posedge clock) begin
        if (reset) begin
            raw_d       <= '0;
            raw_valid_d <= 1'b0;
        end else begin
            raw_d       <= raw_data;
            raw_valid_d <= raw_valid;
        end
    end

    always_comb begin
        path_src = flags[0] ? filt_data : raw_d;
        path_inv = flags[1] ? ~path_src : path_src;
        path_out = path_inv;
        for (int g = 0; g < 4; g++) begin
            if (flags[2 + g]) begin
                path_out[8*g +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_data  <= path_out;
            sample_valid <= raw_valid_d & (state != ST_SETTLE);
        end
    end

endmodule

// File: doc/filter_ctrl.md
# filter_ctrl

Configuration sequencer for the 32-channel input noise filter stage. It latches channel-conditioning flags from the command decoder, defers any flag change until the capture core is not running, and switches the sample path between raw and filtered data without glitches. After each change it blanks the sample-valid stream until the filter pipeline has flushed. It sits between the input synchronizer/noise filter and the sampler.

## Interface
- SETTLE, 3: cycles `sample_valid` is held low after a flag change is applied (≥1).
- clock  in  1  system clock; also clocks the noise filter.
- reset  in  1  synchronous, active-high.
- wr_flags  in  1  one-cycle strobe; `flags_in` is valid.
- flags_in  in  6  bit0 filter_en, bit1 invert, bits[5:2] group disable (group g = channels 8g+7..8g).
- run  in  1  capture core active; flag changes are deferred while high.
- raw_data  in  32  synchronized input samples (the noise filter's input).
- raw_valid  in  1  sample strobe accompanying `raw_data`.
- filt_data  in  32  noise filter output; one cycle behind `raw_data`.
- sample_data  out  32  conditioned samples to the sampler.
- sample_valid  out  1  qualifies `sample_data`.
- flags  out  6  currently applied flags.
- cfg_pending  out  1  a write is waiting for `run` to fall.
- cfg_ack  out  1  one-cycle pulse when a write is applied.

## Operation
- FSM states: ACTIVE, PENDING, APPLY, SETTLE.
- ACTIVE
  - Passes data through.
  - On `wr_flags` with `run`=0: capture `flags_in` into the pending register, then go to APPLY.
  - On `wr_flags` with `run`=1: capture into the pending register, then go to PENDING.
- PENDING
  - `cfg_pending`=1. Data keeps flowing with the old flags.
  - A further `wr_flags` overwrites the pending value; last write wins and only one ack is issued.
  - When `run`=0, go to APPLY.
- APPLY (one cycle)
  - `flags` <= pending value; `cfg_ack`=1; `cfg_pending`=0.
  - Load the settle counter with SETTLE, then go to SETTLE.
- SETTLE
  - `sample_valid` forced to 0.
  - The counter decrements every cycle; at 1 it returns to ACTIVE.
  - A `wr_flags` here is applied immediately, regardless of `run`: `flags` <= `flags_in`, `cfg_ack` pulses the next cycle, and the counter reloads to SETTLE.
- Datapath
  - `raw_data` and `raw_valid` are delayed one register stage, aligning them with `filt_data`.
  - Select source: `filt_data` if filter_en, else delayed raw.
  - Apply XOR with 32'hFFFFFFFF if invert.
  - Zero every byte whose group-disable bit is set.
  - Register the result into `sample_data`. `sample_valid` = delayed `raw_valid` AND (state≠SETTLE).
- `sample_data` updates every cycle whether or not it is valid. Consumers use `sample_valid` only.
- Reset values
  - `flags`=0, `sample_data`=0, `sample_valid`=0, `cfg_pending`=0, `cfg_ack`=0.
  - Pending register = 0; delay stages = 0.
  - State = SETTLE with counter = SETTLE, so the filter flushes after reset.
- Reset during PENDING or APPLY discards the pending write, and no ack is issued.
- `wr_flags` in the same cycle as a `run` 1->0 transition: the `run` value sampled in that cycle decides ACTIVE->PENDING versus ACTIVE->APPLY. No write is lost in either case.

## Timing
- Latency is 2 cycles from `raw_data` and 1 cycle from `filt_data` to `sample_data`/`sample_valid`. Both paths are aligned.
- Write with `run`=0 at cycle t:
  - APPLY at t+1: `cfg_ack`=1 and the new `flags` are visible at t+2.
  - SETTLE at t+2..t+1+SETTLE, with `sample_valid`=0.
  - ACTIVE at t+2+SETTLE; first valid sample with new flags at t+3+SETTLE.
- Write while `run`=1: `cfg_pending` rises at t+1. APPLY occurs the cycle after `run` is first sampled 0.
- `flags` never changes while `run`=1 unless the FSM is already in SETTLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then `raw_valid`=1 with `raw_data`=32'h12345678, flags 0:
  - `sample_valid`=0 for the first SETTLE cycles.
  - Then `sample_data`=32'h12345678, 2 cycles after each input.
- Write flags 6'b000011 with `run`=0:
  - `cfg_ack` one cycle later; `sample_valid` low for 3 cycles.
  - Then `sample_data`=~`filt_data`. Drive `filt_data`=32'h0F0F0F0F and expect 32'hF0F0F0F0.
- `run`=1, write 6'b000001 then 6'b001000:
  - `cfg_pending`=1 and `flags` stays 0 while `run` is high.
  - Drop `run`: exactly one `cfg_ack`, `flags`=6'b001000.
  - `raw_data`=32'hAABBCCDD yields 32'hAABB00DD.
- Write during SETTLE:
  - Settle restarts; `sample_valid` stays low for 3 cycles after the second ack.
  - `flags` equals the second value.
- Assert `reset` while in PENDING:
  - No `cfg_ack`; `flags`=0; `cfg_pending`=0 on the next cycle.
  - The settle blanking sequence follows.
- `wr_flags` in the same cycle as `run` 1->0:
  - The write is applied with exactly one ack.
  - No valid sample carries a mix of old and new flags.
